ysyx_210184_axi_rw: RTL and testbench
=====================================

# ysyx_210184_axi_rw

AXI4 master bridge directly downstream of the core's memory-access controller. It converts the controller's single-request handshake (`r_ena`/`w_ena`, `addr`, `w_data`, byte-expanded mask) into single-beat AXI4 read and write transactions. It returns read data with a completion pulse (`r_ready`/`w_ready`) and handles one outstanding transaction at a time.

## Interface
- `AXI_ADDR_W`, 32, AXI address width; core address truncated to this
- `AXI_DATA_W`, 64, AXI data width (only 64 supported)
- `AXI_ID_W`, 4, AXI ID width
- `AXI_ID`, 0, constant ID driven on AR/AW
- `clk` in 1 — single clock; all logic on posedge
- `rst` in 1 — synchronous, active-high reset
- `r_ena` in 1 — core read request; held until `r_ready` pulse
- `w_ena` in 1 — core write request; held until `w_ready` pulse
- `addr` in 64 — byte address of request
- `w_data` in 64 — write data, lane-aligned
- `w_mask` in 64 — byte-expanded write mask; bit 8i+0 gives strobe i
- `no_Icache` in 1 — uncached access; selects AxCACHE
- `r_data` out 64 — read data, valid in `r_ready` cycle, held afterwards
- `r_ready` out 1 — one-cycle read-complete pulse
- `w_ready` out 1 — one-cycle write-complete pulse
- `resp_err` out 1 — one-cycle pulse with either ready when RRESP/BRESP ≠ OKAY
- AXI AW: `awvalid` out 1, `awready` in 1, `awaddr` out AXI_ADDR_W, `awid` out AXI_ID_W, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awcache` out 4, `awprot` out 3
- AXI W: `wvalid` out 1, `wready` in 1, `wdata` out 64, `wstrb` out 8, `wlast` out 1
- AXI B: `bvalid` in 1, `bready` out 1, `bresp` in 2, `bid` in AXI_ID_W
- AXI AR: `arvalid` out 1, `arready` in 1, `araddr` out AXI_ADDR_W, `arid` out AXI_ID_W, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arcache` out 4, `arprot` out 3
- AXI R: `rvalid` in 1, `rready` out 1, `rdata` in 64, `rresp` in 2, `rlast` in 1, `rid` in AXI_ID_W

## Operation
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- IDLE:
  - `w_ena` → AW_W, which takes priority over `r_ena`.
  - Else `r_ena` → AR.
  - Request fields are captured into registers on that edge.
- AR: `arvalid`=1 until `arvalid&arready`, then go to R.
- R: `rready`=1. On `rvalid&rready`: capture `rdata`, pulse `r_ready` (and `resp_err` if RRESP≠0), then go to DONE.
- AW_W: `awvalid` and `wvalid` both rise on entry.
  - Each drops independently after its own handshake.
  - Go to B once both handshakes are done; they may complete in the same cycle or in either order.
- B: `bready`=1. On `bvalid`: pulse `w_ready` (and `resp_err` if BRESP≠0), then go to DONE.
- DONE: one cycle with no request sampling, so the core can drop its enable. Then go to IDLE.
- Fixed fields:
  - `Axlen`=0, `Axsize`=3, `Axburst`=INCR, `wlast`=1, `Axprot`=0.
  - `Axaddr` = `addr[AXI_ADDR_W-1:3]`,3'b0.
  - `Axcache` = `no_Icache` ? 4'b0000 : 4'b0011.
  - `wstrb[i]` = `w_mask[8i]`.
- `rid`/`bid` are ignored; `rlast` is not checked.
- Reset mid-transaction: the FSM returns to IDLE, all valid/ready outputs drop, and the outstanding AXI transaction is abandoned. The interconnect is reset by the same `rst`.
- Reset values:
  - Every AXI valid/ready output = 0.
  - `r_ready`, `w_ready`, `resp_err` = 0.
  - `r_data` = 0.
  - All address/data/strobe registers = 0.

## Timing
- All outputs are registered. A request sampled in IDLE at edge t puts `arvalid`/`awvalid`/`wvalid` high from cycle t+1.
- AXI valid signals never drop before their handshake, and address/data stay stable while valid (AXI rule).
- Read with zero-wait slave: request at t0, AR handshake at t1, R handshake at t2, `r_ready` high in t3, DONE in t4, IDLE from t5. Minimum four cycles, request-to-ready.
- Write with zero-wait slave: AW+W handshake at t1, B handshake at t2, `w_ready` in t3.
- `r_ready`/`w_ready` are high for exactly one cycle per transaction.

## Structure
- Shared package `ysyx_210184_axi_pkg` holds:
  - the state enum;
  - `AXI_BURST_INCR`=2'b01, `AXI_SIZE_8B`=3'b011, `AXI_RESP_OKAY`=2'b00;
  - the cacheable/uncached AxCACHE constants.
- No sub-module: a single FSM plus capture registers.

## Test plan
- Read: `r_ena`, `addr`=0x8000_0104, slave returns 0x1122334455667788 with 0 waits → `araddr`=0x80000100, `arcache`=0011, `r_ready` at t3, `r_data`=0x1122334455667788.
- Write with AW ready 3 cycles before W: `w_mask`=0x00000000FFFF0000 → `wstrb`=0x0C; `wvalid` held until `wready`; `w_ready` one cycle after B.
- Simultaneous `r_ena`+`w_ena` → write issued first; after `w_ready`, the core drops `w_ena`, and the read is issued only after DONE.
- Held enable: core keeps `r_ena` high one cycle after `r_ready` → exactly one AR transaction.
- Error: BRESP=SLVERR → `w_ready` and `resp_err` pulse together; `no_Icache`=1 → `awcache`=0000.
- Reset asserted while in R with `rvalid` low → next cycle `rready`=0, state IDLE, no `r_ready` pulse.

Source files
------------

// File: rtl/ysyx_210184_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_210184_axi_pkg                                        |
// | Brief   : Shared constants and FSM state encoding for the AXI bridge |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ysyx_210184_axi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_AR   = 3'd1;
  localparam state_t ST_R    = 3'd2;
  localparam state_t ST_AW_W = 3'd3;
  localparam state_t ST_B    = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [3:0] AXI_CACHE_CACHEABLE = 4'b0011;
  localparam logic [3:0] AXI_CACHE_UNCACHED  = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/ysyx_210184_axi_rw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_210184_axi_rw                                         |
// | Brief   : Single-outstanding, single-beat AXI4 master bridge         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_210184_axi_rw
  import ysyx_210184_axi_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    r_ena,
  input  logic                    w_ena,
  input  logic [63:0]             addr,
  input  logic [63:0]             w_data,
  input  logic [63:0]             w_mask,
  input  logic                    no_Icache,
  output logic [63:0]             r_data,
  output logic                    r_ready,
  output logic                    w_ready,
  output logic                    resp_err,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AXI_ADDR_W-1:0]   awaddr,
  output logic [AXI_ID_W-1:0]     awid,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [AXI_ID_W-1:0]     bid,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [AXI_ADDR_W-1:0]   araddr,
  output logic [AXI_ID_W-1:0]     arid,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic [AXI_ID_W-1:0]     rid
);

  localparam logic [AXI_ID_W-1:0] C_ID = AXI_ID[AXI_ID_W-1:0];

  state_t                    r_state;
  logic [AXI_ADDR_W-1:0]     r_addr;
  logic [3:0]                r_cache;
  logic [AXI_DATA_W/8-1:0]   w_strb_next;

  // Byte-expanded mask collapses to one strobe per lane (bit 0 of each byte).
  for (genvar i = 0; i < AXI_DATA_W/8; i++) begin : g_strb
    assign w_strb_next[i] = w_mask[8*i];
  end

  assign awaddr  = r_addr;
  assign araddr  = r_addr;
  assign awcache = r_cache;
  assign arcache = r_cache;
  assign awid    = C_ID;
  assign arid    = C_ID;
  assign awlen   = 8'd0;
  assign arlen   = 8'd0;
  assign awsize  = AXI_SIZE_8B;
  assign arsize  = AXI_SIZE_8B;
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign awprot  = 3'd0;
  assign arprot  = 3'd0;
  assign wlast   = 1'b1;

  wire w_unused = ^{addr, w_mask, rid, bid, rlast};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_cache  <= '0;
      wdata    <= '0;
      wstrb    <= '0;
      r_data   <= '0;
      r_ready  <= 1'b0;
      w_ready  <= 1'b0;
      resp_err <= 1'b0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
    end else begin
      r_ready  <= 1'b0;
      w_ready  <= 1'b0;
      resp_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ena || r_ena) begin
            r_addr  <= {addr[AXI_ADDR_W-1:3], 3'b000};
            r_cache <= no_Icache ? AXI_CACHE_UNCACHED : AXI_CACHE_CACHEABLE;
            if (w_ena) begin
              wdata   <= w_data[AXI_DATA_W-1:0];
              wstrb   <= w_strb_next;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              r_state <= ST_AW_W;
            end else begin
              arvalid <= 1'b1;
              r_state <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            rready   <= 1'b0;
            r_data   <= rdata[63:0];
            r_ready  <= 1'b1;
            resp_err <= (rresp != AXI_RESP_OKAY);
            r_state  <= ST_DONE;
          end
        end
        ST_AW_W: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          // AW and W may finish in either order or together.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            r_state <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready   <= 1'b0;
            w_ready  <= 1'b1;
            resp_err <= (bresp != AXI_RESP_OKAY);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The pulse cycle is entered here; one further quiet cycle lets the core drop its enable.
          if (!(r_ready || w_ready)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_210184_axi_rw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ysyx_210184_axi_rw                                      |
// | Brief   : Directed self-checking bench for the AXI master bridge     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ysyx_210184_axi_rw;

  logic        clk = 1'b0;
  logic        rst, r_ena, w_ena, no_Icache;
  logic [63:0] addr, w_data, w_mask;
  logic [63:0] r_data;
  logic        r_ready, w_ready, resp_err;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, bid, rid, awcache, arcache;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  ysyx_210184_axi_rw dut (
    .clk(clk), .rst(rst), .r_ena(r_ena), .w_ena(w_ena), .addr(addr),
    .w_data(w_data), .w_mask(w_mask), .no_Icache(no_Icache),
    .r_data(r_data), .r_ready(r_ready), .w_ready(w_ready), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awcache(awcache),
    .awprot(awprot), .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready),
    .bresp(bresp), .bid(bid), .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arprot(arprot), .rvalid(rvalid),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  // Slave model: programmable AW/W ready latency, zero-wait AR/R/B.
  int          aw_lat = 0, w_lat = 0, aw_cnt = 0, w_cnt = 0;
  logic        r_hold = 1'b0;
  logic [63:0] rdata_v = '0;
  logic [1:0]  bresp_v = 2'b00;

  initial begin
    awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = 0; bresp = 0; rlast = 1; rid = 0; bid = 0;
  end

  always @(negedge clk) begin
    if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end
    else begin awready = 0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; end
    else begin wready = 0; w_cnt = 0; end
    arready = arvalid;
    rvalid  = rready && !r_hold;
    rdata   = rdata_v;
    bvalid  = bready;
    bresp   = bresp_v;
  end

  int ar_hs = 0, r_ready_cnt = 0;
  always @(posedge clk) begin
    if (arvalid && arready) ar_hs++;
    if (r_ready) r_ready_cnt++;
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int a0, rr0;

  initial begin
    rst = 1; r_ena = 0; w_ena = 0; no_Icache = 0;
    addr = '0; w_data = '0; w_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    check("rst_pulses", {r_ready, w_ready, resp_err}, 0);
    check("rst_r_data", r_data, 0);
    check("rst_araddr", araddr, 0);
    check("rst_wstrb", wstrb, 0);
    rst = 0;
    @(negedge clk);

    // Zero-wait read
    addr = 64'h0000_0000_8000_0104; rdata_v = 64'h1122334455667788; r_ena = 1;
    @(negedge clk);
    check("rd_arvalid", arvalid, 1);
    check("rd_araddr", araddr, 32'h8000_0100);
    check("rd_arcache", arcache, 4'b0011);
    check("rd_fixed", {arlen, arsize, arburst, arprot}, {8'd0, 3'd3, 2'b01, 3'd0});
    @(negedge clk);
    check("rd_rready", rready, 1);
    check("rd_arvalid_drop", arvalid, 0);
    @(negedge clk);
    check("rd_r_ready_t3", r_ready, 1);
    check("rd_r_data", r_data, 64'h1122334455667788);
    check("rd_resp_err", resp_err, 0);
    r_ena = 0;
    @(negedge clk);
    check("rd_r_ready_pulse", r_ready, 0);
    check("rd_r_data_held", r_data, 64'h1122334455667788);
    repeat (2) @(negedge clk);

    // Enable held one cycle past r_ready
    a0 = ar_hs; rr0 = r_ready_cnt;
    addr = 64'h8000_0008; rdata_v = 64'hCAFE_F00D_0000_0001; r_ena = 1;
    for (int i = 0; i < 20 && !r_ready; i++) @(negedge clk);
    check("held_r_ready", r_ready, 1);
    @(negedge clk);
    r_ena = 0;
    repeat (6) @(negedge clk);
    check("held_one_ar", ar_hs - a0, 1);
    check("held_one_pulse", r_ready_cnt - rr0, 1);

    // Write, AW accepted 3 cycles before W
    aw_lat = 0; w_lat = 3;
    addr = 64'h8000_1010; w_data = 64'hA5A5_0000_1234_5678; w_mask = 64'h0000_0000_FFFF_0000;
    w_ena = 1;
    @(negedge clk);
    check("wr_valids", {awvalid, wvalid}, 2'b11);
    check("wr_wstrb", wstrb, 8'h0C);
    check("wr_awaddr", awaddr, 32'h8000_1010);
    check("wr_wdata", wdata, 64'hA5A5_0000_1234_5678);
    check("wr_wlast_cache", {wlast, awcache}, {1'b1, 4'b0011});
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check("wr_aw_dropped", awvalid, 0);
      check("wr_wvalid_held", wvalid, 1);
    end
    @(negedge clk);
    check("wr_b_phase", {wvalid, bready, w_ready}, 3'b010);
    @(negedge clk);
    check("wr_w_ready", w_ready, 1);
    check("wr_resp_err", resp_err, 0);
    w_ena = 0;
    @(negedge clk);
    check("wr_w_ready_pulse", w_ready, 0);
    repeat (2) @(negedge clk);

    // SLVERR on B, uncached
    w_lat = 0; bresp_v = 2'b10; no_Icache = 1; w_mask = '1; addr = 64'h1000_0000; w_ena = 1;
    @(negedge clk);
    check("err_awcache", awcache, 4'b0000);
    check("err_wstrb", wstrb, 8'hFF);
    for (int i = 0; i < 20 && !w_ready; i++) @(negedge clk);
    check("err_w_ready", w_ready, 1);
    check("err_resp_err", resp_err, 1);
    w_ena = 0;
    @(negedge clk);
    check("err_pulse_end", resp_err, 0);
    bresp_v = 2'b00; no_Icache = 0;
    repeat (2) @(negedge clk);

    // Simultaneous read and write: write first
    a0 = ar_hs; addr = 64'h8000_2000; w_mask = 64'hFF; rdata_v = 64'h0BAD_BEEF_0000_0002;
    r_ena = 1; w_ena = 1;
    for (int i = 0; i < 20 && !w_ready; i++) @(negedge clk);
    check("sim_w_ready", w_ready, 1);
    check("sim_no_ar_yet", ar_hs - a0, 0);
    w_ena = 0;
    @(negedge clk);
    check("sim_done_no_ar", arvalid, 0);
    @(negedge clk);
    check("sim_idle_no_ar", arvalid, 0);
    @(negedge clk);
    check("sim_ar_issued", arvalid, 1);
    for (int i = 0; i < 20 && !r_ready; i++) @(negedge clk);
    check("sim_r_ready", r_ready, 1);
    check("sim_r_data", r_data, 64'h0BAD_BEEF_0000_0002);
    r_ena = 0;
    repeat (3) @(negedge clk);
    check("sim_one_ar", ar_hs - a0, 1);

    // Reset while waiting in R
    r_hold = 1; rr0 = r_ready_cnt; addr = 64'h8000_3000; r_ena = 1;
    repeat (2) @(negedge clk);
    check("rst_mid_rready", rready, 1);
    rst = 1; r_ena = 0;
    @(negedge clk);
    check("rst_mid_drop", {rready, arvalid, r_ready}, 0);
    check("rst_mid_r_data", r_data, 0);
    rst = 0; r_hold = 0;
    repeat (4) @(negedge clk);
    check("rst_mid_idle", {rready, arvalid}, 0);
    check("rst_mid_no_pulse", r_ready_cnt - rr0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
